// File: rtl/krz_spim.sv
// Byte-wide SPI master (mode 0) on the KRZ peripheral bus.
// Bus writes fill a TX FIFO that the shift engine drains; received bytes are queued in an RX FIFO.
module krz_spim #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [7:0]  perif_adr_i,
    input  logic [31:0] perif_dat_i,
    input  logic        perif_we_i,
    input  logic        spim_stb_i,
    output logic        spim_ack_o,
    output logic [7:0]  spim_dat_o,
    output logic        spim_sclk_o,
    output logic        spim_mosi_o,
    input  logic        spim_miso_i,
    output logic        spim_csn_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PUSH} state_t;

    state_t      state_q;
    logic        ack_q, csn_q, ovf_q, sclk_q, mosi_q, miso_q;
    logic [7:0]  dat_q, div_q, shreg_q, div_cnt_q;
    logic [4:0]  tog_q;
    logic [AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [7:0]  tx_mem [DEPTH];
    logic [7:0]  rx_mem [DEPTH];

    logic       access, tx_empty, tx_full, rx_empty, rx_full, busy;
    logic       eng_pop, eng_push, tx_push, rx_pop, ovf_set, ovf_clr;
    logic [1:0] reg_sel;
    logic [7:0] tx_head, rx_head, status, rd_data_d;
    logic       unused_bits;

    assign unused_bits = ^{perif_adr_i[7:4], perif_adr_i[1:0], perif_dat_i[31:8]};

    // A held strobe is accepted only every other cycle so the bridge can present its next byte.
    assign access  = spim_stb_i & ~ack_q;
    assign reg_sel = perif_adr_i[3:2];

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = ((tx_wp_q ^ tx_rp_q) == {1'b1, {AW{1'b0}}});
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = ((rx_wp_q ^ rx_rp_q) == {1'b1, {AW{1'b0}}});
    assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];
    assign rx_head  = rx_mem[rx_rp_q[AW-1:0]];

    assign eng_pop  = (state_q == S_IDLE) & ~tx_empty & ~rx_full;
    assign eng_push = (state_q == S_PUSH);
    assign busy     = (state_q != S_IDLE) | ~tx_empty;

    // A push into a full TX still lands when the engine frees a slot on the same edge.
    assign tx_push = access & perif_we_i & (reg_sel == 2'd2) & (~tx_full | eng_pop);
    assign ovf_set = access & perif_we_i & (reg_sel == 2'd2) & tx_full & ~eng_pop;
    assign ovf_clr = access & perif_we_i & (reg_sel == 2'd3) & perif_dat_i[5];
    assign rx_pop  = access & ~perif_we_i & (reg_sel == 2'd2) & ~rx_empty;

    assign status = {2'b00, ovf_q, rx_empty, rx_full, tx_empty, tx_full, busy};

    always_comb begin
        // NOTE: default first so every path assigns rd_data_d and no latch is inferred.
        rd_data_d = 8'h00;
        if (access && !perif_we_i) begin
            case (reg_sel)
                2'd0:    rd_data_d = {7'd0, csn_q};
                2'd1:    rd_data_d = div_q;
                2'd2:    rd_data_d = rx_empty ? 8'h00 : rx_head;
                default: rd_data_d = status;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            ack_q <= 1'b0;
            dat_q <= 8'h00;
            csn_q <= 1'b1;
            div_q <= 8'h03;
            ovf_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ack_q <= access;
            dat_q <= rd_data_d;
            if (access && perif_we_i && reg_sel == 2'd0) csn_q <= perif_dat_i[0];
            if (access && perif_we_i && reg_sel == 2'd1) div_q <= perif_dat_i[7:0];
            if (ovf_set)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            if (tx_push)  tx_wp_q <= tx_wp_q + 1'b1;
            if (eng_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            if (eng_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)   rx_rp_q <= rx_rp_q + 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push)  tx_mem[tx_wp_q[AW-1:0]] <= perif_dat_i[7:0];
        if (eng_push) rx_mem[rx_wp_q[AW-1:0]] <= shreg_q;
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q   <= S_IDLE;
            shreg_q   <= 8'h00;
            miso_q    <= 1'b0;
            div_cnt_q <= 8'h00;
            tog_q     <= 5'd0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (eng_pop) begin
                        shreg_q   <= tx_head;
                        mosi_q    <= tx_head[7];
                        div_cnt_q <= 8'h00;
                        tog_q     <= 5'd0;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (div_cnt_q >= div_q) begin
                        div_cnt_q <= 8'h00;
                        sclk_q    <= ~sclk_q;
                        tog_q     <= tog_q + 5'd1;
                        // MISO is held aside on the rise so the untransmitted LSBs survive until the fall.
                        if (!sclk_q) begin
                            miso_q <= spim_miso_i;
                        end else begin
                            shreg_q <= {shreg_q[6:0], miso_q};
                            mosi_q  <= shreg_q[6];
                        end
                        if (tog_q == 5'd15) state_q <= S_PUSH;
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                S_PUSH:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign spim_ack_o  = ack_q;
    assign spim_dat_o  = dat_q;
    assign spim_sclk_o = sclk_q;
    assign spim_mosi_o = mosi_q;
    assign spim_csn_o  = csn_q;
endmodule

// File: tb/tb_krz_spim.sv
// Bench for krz_spim: queue-based transaction model checked every cycle, plus directed
// scenarios with hand-computed expectations. MISO is looped back to MOSI.
module tb_krz_spim;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstz;
    logic [7:0]  adr;
    logic [31:0] wdat;
    logic        we;
    logic        stb;
    logic        spim_ack_o, spim_sclk_o, spim_mosi_o, spim_csn_o, spim_miso_i;
    logic [7:0]  spim_dat_o;

    int n_checks = 0;
    int n_fail   = 0;

    assign spim_miso_i = spim_mosi_o;

    krz_spim #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rstz        (rstz),
        .perif_adr_i (adr),
        .perif_dat_i (wdat),
        .perif_we_i  (we),
        .spim_stb_i  (stb),
        .spim_ack_o  (spim_ack_o),
        .spim_dat_o  (spim_dat_o),
        .spim_sclk_o (spim_sclk_o),
        .spim_mosi_o (spim_mosi_o),
        .spim_miso_i (spim_miso_i),
        .spim_csn_o  (spim_csn_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: FIFOs as queues, a transfer as "edges since pop".
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_ack, m_csn, m_ovf, m_active;
    logic [7:0] m_dat, m_div, m_byte;
    int         m_k;
    logic       acc, e_pop, e_push, p_push, o_set, o_clr;
    logic [7:0] rdv, st;

    always @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            tx_q.delete();
            rx_q.delete();
            m_ack = 1'b0; m_dat = 8'h00; m_csn = 1'b1; m_div = 8'h03; m_ovf = 1'b0;
            m_active = 1'b0; m_k = 0; m_byte = 8'h00;
        end else begin
            acc    = stb && !m_ack;
            e_push = m_active && (m_k == 16 * (int'(m_div) + 1));
            e_pop  = !m_active && tx_q.size() != 0 && rx_q.size() != DEPTH;
            st     = {2'b00, m_ovf, rx_q.size() == 0, rx_q.size() == DEPTH,
                      tx_q.size() == 0, tx_q.size() == DEPTH, m_active || tx_q.size() != 0};
            rdv = 8'h00; p_push = 1'b0; o_set = 1'b0; o_clr = 1'b0;
            if (acc) begin
                case (adr[3:2])
                    2'd0: if (we) m_csn = wdat[0]; else rdv = {7'd0, m_csn};
                    2'd1: if (we) m_div = wdat[7:0]; else rdv = m_div;
                    2'd2: begin
                        if (we) begin
                            if (tx_q.size() < DEPTH || e_pop) p_push = 1'b1;
                            else o_set = 1'b1;
                        end else if (rx_q.size() != 0) begin
                            rdv = rx_q.pop_front();
                        end
                    end
                    default: if (we) o_clr = wdat[5]; else rdv = st;
                endcase
            end
            if (e_push) begin
                rx_q.push_back(m_byte);
                m_active = 1'b0;
            end else if (m_active) begin
                m_k++;
            end
            if (e_pop) begin
                m_byte = tx_q.pop_front();
                m_active = 1'b1;
                m_k = 0;
            end
            if (p_push) tx_q.push_back(wdat[7:0]);
            if (o_set)      m_ovf = 1'b1;
            else if (o_clr) m_ovf = 1'b0;
            m_ack = acc;
            m_dat = rdv;
        end
    end

    // Compare process: DUT pins against the model on every cycle out of reset.
    always @(negedge clk) begin
        int tog;
        if (rstz) begin
            tog = m_k / (int'(m_div) + 1);
            if (tog > 16) tog = 16;
            check("ack", spim_ack_o, m_ack);
            check("dat", spim_dat_o, m_dat);
            check("csn", spim_csn_o, m_csn);
            check("sclk", spim_sclk_o, m_active ? tog[0] : 1'b0);
            if (m_active && tog < 16)
                check("mosi", spim_mosi_o, m_byte[7 - tog / 2]);
        end
    end

    // One bus access; called at a negedge, returns at the negedge where ACK is seen.
    task automatic bus(input logic [1:0] idx, input logic w, input logic [7:0] d, output logic [7:0] rd);
        logic got = 1'b0;
        adr  = {4'hA, idx, 2'b01};
        wdat = {24'h5C3E91, d};
        we   = w;
        stb  = 1'b1;
        rd   = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (spim_ack_o) begin
                rd  = spim_dat_o;
                got = 1'b1;
                break;
            end
        end
        stb = 1'b0;
        if (!got) check("bus_ack_timeout", 32'd0, 32'd1);
    endtask

    // Collect MOSI at each SCLK rise, up to n rises within a cycle budget.
    task automatic capture(input int n, input int budget, output logic [15:0] bits,
                           output int rises, output int first);
        logic prev = spim_sclk_o;
        bits = 16'h0; rises = 0; first = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (spim_sclk_o && !prev) begin
                bits = {bits[14:0], spim_mosi_o};
                rises++;
                if (rises == 1) first = i + 1;
            end
            prev = spim_sclk_o;
            if (rises == n) break;
        end
    endtask

    logic [7:0]  rd;
    logic [15:0] bits;
    int          rises, first;
    logic [5:0]  ack_pat;
    logic [7:0]  exp_bytes [7];
    logic        got2;

    initial begin
        rstz = 1'b0; stb = 1'b0; adr = 8'h00; wdat = 32'h0; we = 1'b0;
        ack_pat = 6'b101010;
        exp_bytes = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        repeat (3) @(negedge clk);
        check("rst_ack", spim_ack_o, 1'b0);
        check("rst_dat", spim_dat_o, 8'h00);
        check("rst_sclk", spim_sclk_o, 1'b0);
        check("rst_mosi", spim_mosi_o, 1'b0);
        check("rst_csn", spim_csn_o, 1'b1);
        rstz = 1'b1;
        @(negedge clk);
        bus(2'd3, 1'b0, 8'h00, rd); check("rst_status", rd, 8'h14);
        bus(2'd1, 1'b0, 8'h00, rd); check("rst_div", rd, 8'h03);

        // Held strobe on a CTRL read: ACK every other cycle.
        repeat (2) @(negedge clk);
        adr = 8'h00; we = 1'b0; stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            check("ack_pattern", spim_ack_o, ack_pat[i]);
            if (spim_ack_o) check("ack_ctrl_dat", spim_dat_o, 8'h01);
        end
        stb = 1'b0;
        @(negedge clk);

        bus(2'd1, 1'b1, 8'h01, rd);
        bus(2'd0, 1'b1, 8'h00, rd);
        check("csn_low", spim_csn_o, 1'b0);

        // Loopback byte at DIV=1.
        bus(2'd2, 1'b1, 8'hA5, rd);
        capture(8, 60, bits, rises, first);
        check("a5_first_rise", first, 3);
        check("a5_rises", rises, 8);
        check("a5_mosi", bits[7:0], 8'hA5);
        repeat (40) @(negedge clk);
        bus(2'd2, 1'b0, 8'h00, rd); check("a5_rx", rd, 8'hA5);
        bus(2'd3, 1'b0, 8'h00, rd); check("a5_status", rd, 8'h14);

        // Two-byte bridge transaction with a held strobe.
        adr = 8'h08; we = 1'b1; wdat = 32'h0000_0034; stb = 1'b1;
        got2 = 1'b0;
        for (int i = 0; i < 4 && !got2; i++) begin
            @(negedge clk);
            if (spim_ack_o) got2 = 1'b1;
        end
        check("two_ack1", got2, 1'b1);
        wdat = 32'h0000_0012;
        got2 = 1'b0;
        for (int i = 0; i < 4 && !got2; i++) begin
            @(negedge clk);
            if (spim_ack_o) got2 = 1'b1;
        end
        check("two_ack2", got2, 1'b1);
        stb = 1'b0;
        capture(16, 120, bits, rises, first);
        check("two_rises", rises, 16);
        check("two_wire_order", bits, 16'h3412);
        repeat (40) @(negedge clk);
        bus(2'd2, 1'b0, 8'h00, rd); check("two_rx0", rd, 8'h34);
        bus(2'd2, 1'b0, 8'h00, rd); check("two_rx1", rd, 8'h12);

        // Fill RX, stall the engine, then overflow TX.
        for (int i = 1; i <= 4; i++) bus(2'd2, 1'b1, 8'(i * 8'h11), rd);
        repeat (160) @(negedge clk);
        for (int i = 5; i <= 9; i++) bus(2'd2, 1'b1, 8'(i * 8'h11), rd);
        bus(2'd3, 1'b0, 8'h00, rd); check("ovf_status", rd, 8'h2B);
        bus(2'd3, 1'b1, 8'h20, rd);
        bus(2'd3, 1'b0, 8'h00, rd); check("ovf_cleared", rd, 8'h0B);
        bus(2'd2, 1'b0, 8'h00, rd); check("ovf_pop", rd, 8'h11);
        repeat (40) @(negedge clk);
        bus(2'd3, 1'b0, 8'h00, rd); check("resume_status", rd, 8'h09);
        for (int i = 0; i < 4; i++) begin
            bus(2'd2, 1'b0, 8'h00, rd); check("drain_a", rd, exp_bytes[i]);
        end
        repeat (122) @(negedge clk);
        for (int i = 4; i < 7; i++) begin
            bus(2'd2, 1'b0, 8'h00, rd); check("drain_b", rd, exp_bytes[i]);
        end

        // Empty RX read has no side effect.
        bus(2'd3, 1'b0, 8'h00, rd); check("empty_status_pre", rd, 8'h14);
        bus(2'd2, 1'b0, 8'h00, rd); check("empty_read", rd, 8'h00);
        bus(2'd3, 1'b0, 8'h00, rd); check("empty_status_post", rd, 8'h14);

        // Reset mid-transfer.
        bus(2'd2, 1'b1, 8'hC3, rd);
        repeat (10) @(negedge clk);
        rstz = 1'b0;
        #1;
        check("mid_rst_sclk", spim_sclk_o, 1'b0);
        check("mid_rst_mosi", spim_mosi_o, 1'b0);
        check("mid_rst_csn", spim_csn_o, 1'b1);
        check("mid_rst_ack", spim_ack_o, 1'b0);
        @(negedge clk);
        rstz = 1'b1;
        @(negedge clk);
        bus(2'd3, 1'b0, 8'h00, rd); check("mid_rst_status", rd, 8'h14);
        bus(2'd1, 1'b0, 8'h00, rd); check("mid_rst_div", rd, 8'h03);
        bus(2'd0, 1'b0, 8'h00, rd); check("mid_rst_ctrl", rd, 8'h01);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
